// File: rtl/stage4_types_pkg.sv
// Shared types for the four-stage pipeline controller: FSM states, redirect
// selector encoding and the bundle of per-cycle pipeline control strobes.
package stage4_types_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DFLUSH = 3'd1,
    ST_IFLUSH = 3'd2,
    ST_SLEEP  = 3'd3,
    ST_HALT   = 3'd4
  } pipe_ctrl_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BRJ  = 2'd1,
    SEL_TRAP = 2'd2,
    SEL_PC4  = 2'd3
  } redirect_sel_t;

  typedef struct packed {
    logic          if_stall;
    logic          if_flush;
    logic          ex_stall;
    logic          ex_flush;
    logic          pc_redirect;
    redirect_sel_t sel;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_IDLE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEL_NONE};
  localparam pipe_ctl_t CTL_TRAP    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SEL_TRAP};
  localparam pipe_ctl_t CTL_BRJ     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, SEL_BRJ};
  localparam pipe_ctl_t CTL_HOLD    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, SEL_NONE};
  localparam pipe_ctl_t CTL_BUBBLE  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, SEL_NONE};
  localparam pipe_ctl_t CTL_FENCE   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, SEL_NONE};
  localparam pipe_ctl_t CTL_REFETCH = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, SEL_PC4};

  localparam int unsigned WDOG_MIN_WIDTH = 12;

  // Counter width able to hold the timeout limit, never below 12 bits.
  function automatic int unsigned wdog_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 32'd1);
    if (w < WDOG_MIN_WIDTH) begin
      return WDOG_MIN_WIDTH;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/flush_watchdog.sv
// Cycle watchdog shared by the D-cache and I-cache flush handshakes: restarts on
// entry into a flush state, reports expiry, and keeps a sticky timeout flag.
module flush_watchdog
  import stage4_types_pkg::*;
#(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic restart,
  output logic expired,
  output logic timeout_flag
);

  localparam int CW = int'(wdog_width(LIMIT));
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 32'd1);

  logic [CW-1:0] cnt_r;
  logic          flag_r;

  // The LIMIT-th cycle spent in a flush state counts as expiry.
  assign expired      = active && (cnt_r == LAST);
  assign timeout_flag = flag_r;

  // Cycle counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      flag_r <= 1'b0;
    end else begin
      if (restart) begin
        cnt_r <= '0;
      end else if (active && (cnt_r != LAST)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      flag_r <= flag_r | expired;
    end
  end

endmodule

// File: rtl/stage4_pipe_ctrl.sv
// Hazard and sequencing controller for the four-stage pipeline: stall/flush
// strobes, PC redirect selection, FENCE.I cache flushes, WFI sleep and halt.
module stage4_pipe_ctrl
  import stage4_types_pkg::*;
#(
  parameter int unsigned FLUSH_TIMEOUT = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_mem_valid,
  input  logic        ex_ifence,
  input  logic        ex_wfi,
  input  logic        ex_halt,
  input  logic        ex_dren,
  input  logic        ex_dwen,
  input  logic        dmem_busy,
  input  logic        imem_busy,
  input  logic        load_use_hazard,
  input  logic        mispredict,
  input  logic        trap_req,
  input  logic        intr_pending,
  input  logic        dflush_done,
  input  logic        iflush_done,
  output logic        dflush_req,
  output logic        iflush_req,
  output logic        if_stall,
  output logic        if_flush,
  output logic        ex_stall,
  output logic        ex_flush,
  output logic        pc_redirect,
  output logic [1:0]  redirect_sel,
  output logic        halted,
  output logic        flush_timeout,
  output logic [31:0] stall_cycles
);

  pipe_ctrl_state_t state_r;
  pipe_ctrl_state_t state_nxt_s;
  pipe_ctl_t        ctl_s;
  pipe_ctl_t        ctl_out_s;
  logic             dflush_req_r;
  logic             iflush_req_r;
  logic             halted_r;
  logic             trap_pending_r;
  logic [31:0]      stall_cycles_r;
  logic             in_flush_s;
  logic             wd_restart_s;
  logic             wd_expired_s;
  logic             wd_flag_s;
  logic             mem_stall_s;

  assign in_flush_s   = (state_r == ST_DFLUSH) || (state_r == ST_IFLUSH);
  assign wd_restart_s = (state_nxt_s != state_r) &&
                        ((state_nxt_s == ST_DFLUSH) || (state_nxt_s == ST_IFLUSH));
  assign mem_stall_s  = (dmem_busy && (ex_dren || ex_dwen)) || imem_busy;

  flush_watchdog #(
    .LIMIT(FLUSH_TIMEOUT)
  ) u_flush_watchdog (
    .clk         (CLK),
    .rst         (RST),
    .active      (in_flush_s),
    .restart     (wd_restart_s),
    .expired     (wd_expired_s),
    .timeout_flag(wd_flag_s)
  );

  // Next state and same-cycle pipeline strobes
  always_comb begin
    ctl_s       = CTL_IDLE;
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (trap_req) begin
          ctl_s = CTL_TRAP;
        end else if (mispredict && ex_mem_valid) begin
          ctl_s = CTL_BRJ;
        end else if (ex_mem_valid && ex_ifence) begin
          // Outstanding data traffic must drain before the D-cache is flushed.
          if (dmem_busy) begin
            ctl_s = CTL_HOLD;
          end else begin
            ctl_s       = CTL_FENCE;
            state_nxt_s = ST_DFLUSH;
          end
        end else if (ex_mem_valid && ex_wfi && !intr_pending) begin
          ctl_s       = CTL_HOLD;
          state_nxt_s = ST_SLEEP;
        end else if (ex_mem_valid && ex_halt) begin
          ctl_s       = CTL_HOLD;
          state_nxt_s = ST_HALT;
        end else if (mem_stall_s) begin
          ctl_s = CTL_HOLD;
        end else if (load_use_hazard) begin
          ctl_s = CTL_BUBBLE;
        end else begin
          ctl_s = CTL_IDLE;
        end
      end
      ST_DFLUSH: begin
        ctl_s = CTL_FENCE;
        if ((dflush_done && dflush_req_r) || wd_expired_s) begin
          state_nxt_s = ST_IFLUSH;
        end else begin
          state_nxt_s = ST_DFLUSH;
        end
      end
      ST_IFLUSH: begin
        // A trap raised during the flush replaces the pc4 refetch.
        if ((iflush_done && iflush_req_r) || wd_expired_s) begin
          state_nxt_s = ST_RUN;
          ctl_s       = (trap_pending_r || trap_req) ? CTL_TRAP : CTL_REFETCH;
        end else begin
          ctl_s = CTL_FENCE;
        end
      end
      ST_SLEEP: begin
        if (trap_req) begin
          ctl_s       = CTL_TRAP;
          state_nxt_s = ST_RUN;
        end else if (intr_pending) begin
          ctl_s       = CTL_IDLE;
          state_nxt_s = ST_RUN;
        end else begin
          ctl_s = CTL_HOLD;
        end
      end
      ST_HALT: begin
        ctl_s = CTL_HOLD;
      end
      default: begin
        ctl_s       = CTL_IDLE;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Force every strobe low while reset is asserted, regardless of inputs
  always_comb begin
    if (RST) begin
      ctl_out_s = CTL_IDLE;
    end else begin
      ctl_out_s = ctl_s;
    end
  end

  assign if_stall      = ctl_out_s.if_stall;
  assign if_flush      = ctl_out_s.if_flush;
  assign ex_stall      = ctl_out_s.ex_stall;
  assign ex_flush      = ctl_out_s.ex_flush;
  assign pc_redirect   = ctl_out_s.pc_redirect;
  assign redirect_sel  = ctl_out_s.sel;
  assign dflush_req    = dflush_req_r;
  assign iflush_req    = iflush_req_r;
  assign halted        = halted_r;
  assign flush_timeout = wd_flag_s;
  assign stall_cycles  = stall_cycles_r;

  // Controller state, flush requests, halt flag and deferred trap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r        <= ST_RUN;
      dflush_req_r   <= 1'b0;
      iflush_req_r   <= 1'b0;
      halted_r       <= 1'b0;
      trap_pending_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      dflush_req_r <= (state_nxt_s == ST_DFLUSH);
      iflush_req_r <= (state_nxt_s == ST_IFLUSH);
      halted_r     <= (state_nxt_s == ST_HALT);
      if (state_nxt_s == ST_RUN) begin
        trap_pending_r <= 1'b0;
      end else if (in_flush_s && trap_req) begin
        trap_pending_r <= 1'b1;
      end else begin
        trap_pending_r <= trap_pending_r;
      end
    end
  end

  // Stalled-cycle performance counter, wraps at 2^32
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_r <= 32'd0;
    end else if (ctl_s.if_stall) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

endmodule
